// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter register stage with run/halt control and a saturating
// retired-instruction counter. Each cycle in RUN the PC either steps by one,
// adds a signed branch offset, or holds (stall / halt). The PC drives
// instruction memory, so every output here is registered.
//
// Optional feature macro: PC_LINK_EN
//   When defined, adds call_i / ret_i inputs and a link_addr_o output so a
//   single-level subroutine call/return can be sequenced.
//
// Parameters:
//   D      PC and branch offset width; PC arithmetic is modulo 2^D
//   CNT_W  retired-instruction counter width
//
// Ports:
//   clk_i           system clock, rising-edge active
//   reset_n_i       synchronous active-low reset
//   start_i         begin execution at start_addr_i (IDLE or HALTED only)
//   start_addr_i    entry address loaded on start
//   target_i        signed two's-complement branch offset
//   branch_taken_i  current instruction branches by target_i
//   halt_i          current instruction is a halt
//   stall_i         freeze PC, state and counter this cycle
//   call_i          (PC_LINK_EN) call: link = pc+1, pc = pc + target_i
//   ret_i           (PC_LINK_EN) return: pc = link
//   pc_o            current program counter
//   running_o       high while in RUN
//   done_o          high while in HALTED
//   retired_o       instructions completed since the last start (saturating)
//   link_addr_o     (PC_LINK_EN) return address captured by the last call
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter int D     = 12,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic [D-1:0]     start_addr_i,
   input  logic [D-1:0]     target_i,
   input  logic             branch_taken_i,
   input  logic             halt_i,
   input  logic             stall_i,
`ifdef PC_LINK_EN
   input  logic             call_i,
   input  logic             ret_i,
   output logic [D-1:0]     link_addr_o,
`endif
   output logic [D-1:0]     pc_o,
   output logic             running_o,
   output logic             done_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StRun    = 2'b01,
      StHalted = 2'b10
   } state_e;

   localparam logic [D-1:0]     PcOne  = 1;
   localparam logic [CNT_W-1:0] CntOne = 1;

   state_e           state_q,   state_d;
   logic [D-1:0]     pc_q,      pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             running_q, done_q;
   logic [CNT_W-1:0] retiredInc;
`ifdef PC_LINK_EN
   logic [D-1:0]     linkAddr_q, linkAddr_d;
`endif

   // Counter saturates at all-ones instead of wrapping back to zero.
   assign retiredInc = (retired_q == '1) ? retired_q : retired_q + CntOne;

   // Next-state logic. An unsigned D-bit add of the offset gives exactly the
   // signed sum truncated to D bits, so no sign extension is needed.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
`ifdef PC_LINK_EN
      linkAddr_d = linkAddr_q;
`endif
      case (state_q)
         StIdle, StHalted: begin
            if (start_i) begin
               state_d   = StRun;
               pc_d      = start_addr_i;
               retired_d = '0;
            end
         end
         StRun: begin
            if (stall_i) begin
               state_d = StRun;
            end else if (halt_i) begin
               state_d   = StHalted;
               retired_d = retiredInc;
`ifdef PC_LINK_EN
            end else if (ret_i) begin
               pc_d      = linkAddr_q;
               retired_d = retiredInc;
            end else if (call_i) begin
               linkAddr_d = pc_q + PcOne;
               pc_d       = pc_q + target_i;
               retired_d  = retiredInc;
`endif
            end else if (branch_taken_i) begin
               pc_d      = pc_q + target_i;
               retired_d = retiredInc;
            end else begin
               pc_d      = pc_q + PcOne;
               retired_d = retiredInc;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register; running/done are decoded from the next state so they
   // are registered alongside it rather than derived combinationally.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         retired_q  <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef PC_LINK_EN
         linkAddr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         retired_q  <= retired_d;
         running_q  <= (state_d == StRun);
         done_q     <= (state_d == StHalted);
`ifdef PC_LINK_EN
         linkAddr_q <= linkAddr_d;
`endif
      end
   end

   assign pc_o      = pc_q;
   assign running_o = running_q;
   assign done_o    = done_q;
   assign retired_o = retired_q;
`ifdef PC_LINK_EN
   assign link_addr_o = linkAddr_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer, built with CNT_W=4 so counter
// saturation is reached quickly. Directed scenarios walk through reset,
// start, branching, wrap-around, stall/halt, saturation and mid-run reset,
// followed by a randomized run. Every cycle is compared against a
// behavioural model that tracks PC, run state and retired count with plain
// integer arithmetic. Link/return checks apply when PC_LINK_EN is defined.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int D      = 12;
   localparam int CNT_W  = 4;
   localparam int PcMod  = 1 << D;
   localparam int CntMax = (1 << CNT_W) - 1;
   localparam int MIdle = 0, MRun = 1, MHalted = 2;

   logic             clk = 1'b0;
   logic             resetN, start, branchTaken, halt, stall, call, ret;
   logic [D-1:0]     startAddr, target;
   logic [D-1:0]     pc;
   logic             running, done;
   logic [CNT_W-1:0] retired;
`ifdef PC_LINK_EN
   logic [D-1:0]     linkAddr;
`endif

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state
   int mPc = 0, mState = MIdle, mRetired = 0, mLink = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.D(D), .CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .reset_n_i      (resetN),
      .start_i        (start),
      .start_addr_i   (startAddr),
      .target_i       (target),
      .branch_taken_i (branchTaken),
      .halt_i         (halt),
      .stall_i        (stall),
`ifdef PC_LINK_EN
      .call_i         (call),
      .ret_i          (ret),
      .link_addr_o    (linkAddr),
`endif
      .pc_o           (pc),
      .running_o      (running),
      .done_o         (done),
      .retired_o      (retired)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int wrapPc(input int x);
      return ((x % PcMod) + PcMod) % PcMod;
   endfunction

   function automatic int signedOffset(input logic [D-1:0] t);
      int v;
      v = int'(t);
      return (v >= PcMod / 2) ? v - PcMod : v;
   endfunction

   // Architectural behaviour of one clock edge given the sampled inputs.
   task automatic modelStep(input logic rst, st, input logic [D-1:0] sa, tg,
                            input logic br, hl, sl, cl, rt);
      if (!rst) begin
         mPc = 0; mState = MIdle; mRetired = 0; mLink = 0;
      end else if (mState != MRun) begin
         if (st) begin
            mPc = int'(sa); mState = MRun; mRetired = 0;
         end
      end else if (!sl) begin
         if (hl) begin
            mState = MHalted;
         end else if (rt) begin
            mPc = mLink;
         end else if (cl) begin
            mLink = wrapPc(mPc + 1);
            mPc   = wrapPc(mPc + signedOffset(tg));
         end else if (br) begin
            mPc = wrapPc(mPc + signedOffset(tg));
         end else begin
            mPc = wrapPc(mPc + 1);
         end
         mRetired = (mRetired < CntMax) ? mRetired + 1 : CntMax;
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".pc"},      32'(pc),      32'(mPc));
      checkOutput({tag, ".running"}, 32'(running), 32'(mState == MRun));
      checkOutput({tag, ".done"},    32'(done),    32'(mState == MHalted));
      checkOutput({tag, ".retired"}, 32'(retired), 32'(mRetired));
`ifdef PC_LINK_EN
      checkOutput({tag, ".link"},    32'(linkAddr), 32'(mLink));
`endif
   endtask

   // Drive one cycle of inputs, advance model at the edge, compare #1 later.
   task automatic applyStimulus(input string tag, input logic rst, st,
                                input logic [D-1:0] sa, tg,
                                input logic br, hl, sl, cl, rt);
      resetN = rst; start = st; startAddr = sa; target = tg;
      branchTaken = br; halt = hl; stall = sl;
`ifdef PC_LINK_EN
      call = cl; ret = rt;
`else
      call = 1'b0; ret = 1'b0;
`endif
      @(posedge clk);
      modelStep(rst, st, sa, tg, br, hl, sl, call, ret);
      #1;
      checkModel(tag);
   endtask

   // Shorthands for common cycles
   task automatic stepInc(input string tag);
      applyStimulus(tag, 1, 0, '0, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic stepBranch(input string tag, input logic [D-1:0] tg);
      applyStimulus(tag, 1, 0, '0, tg, 1, 0, 0, 0, 0);
   endtask

   task automatic stepStart(input string tag, input logic [D-1:0] sa);
      applyStimulus(tag, 1, 1, sa, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic stepHalt(input string tag);
      applyStimulus(tag, 1, 0, '0, '0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      resetN = 1'b0; start = 1'b0; startAddr = '0; target = '0;
      branchTaken = 1'b0; halt = 1'b0; stall = 1'b0; call = 1'b0; ret = 1'b0;

      // Reset held two cycles with start asserted
      applyStimulus("rst0", 0, 1, 12'h123, '0, 0, 0, 0, 0, 0);
      applyStimulus("rst1", 0, 1, 12'h123, '0, 0, 0, 0, 0, 0);
      checkOutput("rst.pc", 32'(pc), 32'h0);
      checkOutput("rst.running", 32'(running), 32'h0);
      checkOutput("rst.done", 32'(done), 32'h0);

      // Start and free-run
      stepStart("start40", 12'h040);
      checkOutput("start40.pc", 32'(pc), 32'h040);
      checkOutput("start40.running", 32'(running), 32'h1);
      for (int i = 0; i < 3; i++) stepInc($sformatf("run%0d", i));
      checkOutput("run3.pc", 32'(pc), 32'h043);
      checkOutput("run3.retired", 32'(retired), 32'h3);

      // Branch backward then forward, then zero-offset spin
      stepHalt("halt1");
      stepStart("start100", 12'h100);
      stepBranch("brBack", 12'hF97);
      checkOutput("brBack.pc", 32'(pc), 32'h097);
      stepBranch("brFwd", 12'h009);
      checkOutput("brFwd.pc", 32'(pc), 32'h0A0);
      stepBranch("brSpin", 12'h000);
      checkOutput("brSpin.pc", 32'(pc), 32'h0A0);
      checkOutput("brSpin.retired", 32'(retired), 32'h3);

      // Wrap-around on increment and on negative branch
      stepHalt("halt2");
      stepStart("startFFE", 12'hFFE);
      stepInc("wrapInc0");
      checkOutput("wrapInc0.pc", 32'(pc), 32'hFFF);
      stepInc("wrapInc1");
      checkOutput("wrapInc1.pc", 32'(pc), 32'h000);
      for (int i = 0; i < 3; i++) stepInc($sformatf("toThree%0d", i));
      stepBranch("wrapBr", 12'hFF0);
      checkOutput("wrapBr.pc", 32'(pc), 32'hFF3);

      // Stall dominates halt and branch
      for (int i = 0; i < 2; i++)
         applyStimulus($sformatf("stall%0d", i), 1, 0, '0, 12'h055, 1, 1, 1, 0, 0);
      checkOutput("stall.pc", 32'(pc), 32'hFF3);
      checkOutput("stall.running", 32'(running), 32'h1);
      applyStimulus("haltBr", 1, 0, '0, 12'h055, 1, 1, 0, 0, 0);
      checkOutput("haltBr.done", 32'(done), 32'h1);
      checkOutput("haltBr.pc", 32'(pc), 32'hFF3);
      stepBranch("haltedHold", 12'h010);
      checkOutput("haltedHold.pc", 32'(pc), 32'hFF3);
      stepStart("start200", 12'h200);
      checkOutput("start200.pc", 32'(pc), 32'h200);
      checkOutput("start200.retired", 32'(retired), 32'h0);

      // Saturation of the 4-bit counter, then reset mid-branch
      for (int i = 0; i < 20; i++) stepInc($sformatf("sat%0d", i));
      checkOutput("sat.retired", 32'(retired), 32'hF);
      checkOutput("sat.pc", 32'(pc), 32'h214);
      applyStimulus("midRst", 0, 0, '0, 12'h100, 1, 0, 0, 0, 0);
      checkOutput("midRst.pc", 32'(pc), 32'h0);
      checkOutput("midRst.running", 32'(running), 32'h0);

`ifdef PC_LINK_EN
      // Call and return through the link register
      stepStart("start010", 12'h010);
      applyStimulus("call", 1, 0, '0, 12'h020, 0, 0, 0, 1, 0);
      checkOutput("call.pc", 32'(pc), 32'h030);
      checkOutput("call.link", 32'(linkAddr), 32'h011);
      applyStimulus("ret", 1, 0, '0, '0, 0, 0, 0, 0, 1);
      checkOutput("ret.pc", 32'(pc), 32'h011);
`endif

      // Randomized run against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus($sformatf("rand%0d", i),
                       ($urandom_range(63) != 0),
                       ($urandom_range(7) == 0),
                       D'($urandom),
                       D'($urandom),
                       ($urandom_range(2) == 0),
                       ($urandom_range(15) == 0),
                       ($urandom_range(5) == 0),
                       ($urandom_range(9) == 0),
                       ($urandom_range(9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
